// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver with 16x oversampling and a majority vote on samples 7/8/9.
// Delivers received bytes through a valid/ready register and flags framing errors and overruns.
module uart_rx_stream #(
    parameter int DIV   = 65,
    parameter int DIV_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [DIV_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [3:0]         samp_cnt_q, samp_cnt_d;
    logic               s7_q, s7_d;
    logic               s8_q, s8_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;

    logic               rxs;
    logic               tick;
    logic               decide;
    logic               maj;
    logic               byte_done;

    assign rxs    = sync2_q;
    assign tick   = (tick_cnt_q == DIV_W'(DIV - 1));
    assign decide = tick && (samp_cnt_q == 4'd9);
    assign maj    = (s7_q & s8_q) | (s7_q & rxs) | (s8_q & rxs);

    always_comb begin
        sync1_d     = rx_i;
        sync2_d     = sync1_q;
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
        samp_cnt_d  = tick ? samp_cnt_q + 4'd1 : samp_cnt_q;
        s7_d        = (tick && samp_cnt_q == 4'd7) ? rxs : s7_q;
        s8_d        = (tick && samp_cnt_q == 4'd8) ? rxs : s8_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        byte_done   = 1'b0;

        // Counters are held at zero in IDLE so the bit phase starts at the falling edge.
        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                samp_cnt_d = '0;
                if (!rxs) begin
                    state_d = START;
                end
            end
            START: begin
                if (decide) begin
                    if (maj) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_d[bit_idx_q] = maj;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (decide) begin
                    state_d = IDLE;
                    if (maj) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A completed byte may replace the held one only if it is being accepted this cycle.
        if (byte_done) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shreg_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            tick_cnt_q  <= '0;
            samp_cnt_q  <= '0;
            s7_q        <= 1'b0;
            s8_q        <= 1'b0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            tick_cnt_q  <= tick_cnt_d;
            samp_cnt_q  <= samp_cnt_d;
            s7_q        <= s7_d;
            s8_q        <= s8_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Testbench for uart_rx_stream: drives 8N1 frames at DIV=4 and checks the byte stream
// against a scoreboard of expected bytes, plus error-pulse counts and reset behaviour.
module tb_uart_rx_stream;

    localparam int DIV = 4;
    localparam int BIT = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int assertCount = 0;
    int failCount = 0;

    logic [7:0] expQ[$];
    int validCycles = 0;
    int feCount = 0;
    int ovCount = 0;
    int busyRises = 0;
    int feRun = 0;
    int ovRun = 0;
    logic busyPrev = 1'b0;

    uart_rx_stream #(.DIV(DIV), .DIV_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_i     (rx_i),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sampled on the falling edge: inputs are already set for the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) validCycles++;
            if (rx_valid && rx_ready) begin
                if (expQ.size() == 0)
                    checkOutput("sbUnexpected", 32'(rx_data), 32'hFFFF_FFFF);
                else
                    checkOutput("sbData", 32'(rx_data), 32'(expQ.pop_front()));
            end
            if (frame_err) begin
                if (feRun == 0) feCount++;
                feRun++;
            end else if (feRun > 0) begin
                checkOutput("feWidth", 32'(feRun), 32'd1);
                feRun = 0;
            end
            if (overrun) begin
                if (ovRun == 0) ovCount++;
                ovRun++;
            end else if (ovRun > 0) begin
                checkOutput("ovWidth", 32'(ovRun), 32'd1);
                ovRun = 0;
            end
            if (busy && !busyPrev) busyRises++;
            busyPrev = busy;
        end
    end

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        rx_i = 1'b1;
        for (int i = 0; i < n; i++) stepClk();
    endtask

    // One 8N1 frame; glitchAt forces the line low for that cycle, abortAt stops driving early.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input int glitchAt, input int abortAt);
        logic [7:0] d;
        d = data;
        for (int cyc = 0; cyc < 10 * BIT; cyc++) begin
            int b;
            if (cyc == abortAt) return;
            b = cyc / BIT;
            if (b == 0)      rx_i = 1'b0;
            else if (b == 9) rx_i = stopBit;
            else             rx_i = d[b - 1];
            if (cyc == glitchAt) rx_i = 1'b0;
            stepClk();
        end
        rx_i = 1'b1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_data"}, 32'(rx_data), 32'd0);
        checkOutput({tag, "_valid"}, 32'(rx_valid), 32'd0);
        checkOutput({tag, "_fe"}, 32'(frame_err), 32'd0);
        checkOutput({tag, "_ov"}, 32'(overrun), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int v0, fe0, ov0, b0;

        rst_n = 1'b0;
        repeat (3) stepClk();
        checkResetOutputs("reset");
        rst_n = 1'b1;
        idleCycles(20);

        $display("[TB] single byte 0xA5 with rx_ready=1");
        rx_ready = 1'b1;
        v0 = validCycles; fe0 = feCount; ov0 = ovCount;
        expQ.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1, -1, -1);
        checkOutput("a5Drained", 32'(expQ.size()), 32'd0);
        checkOutput("a5ValidWidth", 32'(validCycles - v0), 32'd1);
        checkOutput("a5NoFe", 32'(feCount - fe0), 32'd0);
        checkOutput("a5NoOv", 32'(ovCount - ov0), 32'd0);
        idleCycles(32);
        checkOutput("a5BusyIdle", 32'(busy), 32'd0);

        $display("[TB] overrun: 0x3C then 0xC3 with rx_ready=0");
        rx_ready = 1'b0;
        ov0 = ovCount; fe0 = feCount;
        expQ.push_back(8'h3C);
        applyStimulus(8'h3C, 1'b1, -1, -1);
        applyStimulus(8'hC3, 1'b1, -1, -1);
        idleCycles(16);
        checkOutput("ovPulses", 32'(ovCount - ov0), 32'd1);
        checkOutput("ovNoFe", 32'(feCount - fe0), 32'd0);
        checkOutput("ovHeldValid", 32'(rx_valid), 32'd1);
        checkOutput("ovHeldData", 32'(rx_data), 32'h3C);
        rx_ready = 1'b1;
        stepClk();
        rx_ready = 1'b0;
        stepClk();
        checkOutput("ovAccepted", 32'(rx_valid), 32'd0);
        checkOutput("ovDataHold", 32'(rx_data), 32'h3C);
        checkOutput("ovDrained", 32'(expQ.size()), 32'd0);

        $display("[TB] framing error on 0x55, then 0x0F");
        rx_ready = 1'b1;
        v0 = validCycles; fe0 = feCount; ov0 = ovCount;
        applyStimulus(8'h55, 1'b0, -1, -1);
        idleCycles(2 * BIT);
        checkOutput("feOnePulse", 32'(feCount - fe0), 32'd1);
        checkOutput("feNoValid", 32'(validCycles - v0), 32'd0);
        checkOutput("feNoOv", 32'(ovCount - ov0), 32'd0);
        expQ.push_back(8'h0F);
        applyStimulus(8'h0F, 1'b1, -1, -1);
        idleCycles(32);
        checkOutput("feRecovered", 32'(expQ.size()), 32'd0);
        checkOutput("feNoExtra", 32'(feCount - fe0), 32'd1);

        $display("[TB] 20-cycle glitch on idle line");
        v0 = validCycles; fe0 = feCount; ov0 = ovCount; b0 = busyRises;
        rx_i = 1'b0;
        repeat (20) stepClk();
        idleCycles(80);
        checkOutput("glBusyRose", 32'(busyRises - b0), 32'd1);
        checkOutput("glBusyIdle", 32'(busy), 32'd0);
        checkOutput("glNoValid", 32'(validCycles - v0), 32'd0);
        checkOutput("glNoFe", 32'(feCount - fe0), 32'd0);
        checkOutput("glNoOv", 32'(ovCount - ov0), 32'd0);

        $display("[TB] 0xFF with a one-cycle glitch mid data bit 3");
        expQ.push_back(8'hFF);
        applyStimulus(8'hFF, 1'b1, 4 * BIT + 36, -1);
        idleCycles(32);
        checkOutput("majDrained", 32'(expQ.size()), 32'd0);

        $display("[TB] reset during data bit 4 of 0x81, then 0x7E");
        applyStimulus(8'h81, 1'b1, -1, 5 * BIT + 32);
        rst_n = 1'b0;
        rx_i = 1'b1;
        repeat (2) stepClk();
        checkResetOutputs("midReset");
        rst_n = 1'b1;
        idleCycles(32);
        v0 = validCycles;
        expQ.push_back(8'h7E);
        applyStimulus(8'h7E, 1'b1, -1, -1);
        idleCycles(32);
        checkOutput("rstDrained", 32'(expQ.size()), 32'd0);
        checkOutput("rstOneByte", 32'(validCycles - v0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
